alu_multicycle: RTL

Parametrised, handshaked successor of the 32-bit combinational ALU. It implements the full RV32I/RV64I ALU operation set: add/sub, xor, or, and, sll, srl/sra, slt and sltu. Shifts are iterative (one bit position per cycle) to save area; all other operations complete in one cycle. The block sits between decode/operand-select and writeback in the NPC execute stage, with a valid/ready pair on each side.

---
 rtl/alu_multicycle.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked RV32I/RV64I ALU for the execute stage.
//
// Operations (sel): 0 add/sub, 1 xor, 2 or, 3 and, 4 sll, 5 srl/sra, 6 slt, 7 sltu,
// 8-15 reserved (result 0). funct7 == 7'h20 selects sub / sra.
// Shifts run one bit per cycle unless ALU_BARREL_SHIFT_EN is defined, in which case
// every operation completes in one cycle through a combinational barrel shifter.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   request present
//   in_ready   request can be accepted (IDLE and not in reset)
//   in1, in2   operands; shifts use in2[SHAMT_W-1:0]
//   funct7     7'h20 selects sub / sra
//   sel        operation select
//   out_valid  result valid (DONE state)
//   out_ready  consumer accepts result
//   out        registered result, stable while out_valid is high
//
// Macro: ALU_BARREL_SHIFT_EN (undefined by default -> iterative shifter).

module alu_multicycle #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [6:0]       funct7,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
);

`ifdef ALU_BARREL_SHIFT_EN
    typedef enum logic [1:0] {StIdle, StDone} state_e;
`else
    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
`endif

    state_e state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] imm_res;
    logic [SHAMT_W-1:0] shamt;
    logic alt;
    logic accept;

    assign alt    = (funct7 == 7'h20);
    assign shamt  = in2[SHAMT_W-1:0];
    assign accept = in_valid && in_ready;

    // Single-cycle result for everything the accept edge can finish on its own.
    always_comb begin
        imm_res = '0;
        case (sel)
            4'd0: imm_res = in1 + (alt ? ~in2 : in2) + {{(WIDTH-1){1'b0}}, alt};
            4'd1: imm_res = in1 ^ in2;
            4'd2: imm_res = in1 | in2;
            4'd3: imm_res = in1 & in2;
`ifdef ALU_BARREL_SHIFT_EN
            4'd4: imm_res = in1 << shamt;
            4'd5: imm_res = alt ? WIDTH'($signed(in1) >>> shamt) : (in1 >> shamt);
`else
            // Only reached with shamt 0; nonzero shifts go through the SHIFT state.
            4'd4: imm_res = in1;
            4'd5: imm_res = in1;
`endif
            4'd6: imm_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            4'd7: imm_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
            default: imm_res = '0;
        endcase
    end

`ifndef ALU_BARREL_SHIFT_EN
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               left_q, left_d;
    logic               arith_q, arith_d;
    logic [WIDTH-1:0]   shifted;
    logic               is_shift;

    assign is_shift = (sel == 4'd4) || (sel == 4'd5);
    assign shifted  = left_q ? {acc_q[WIDTH-2:0], 1'b0}
                             : {arith_q & acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
`endif

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
`ifndef ALU_BARREL_SHIFT_EN
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        arith_d = arith_q;
`endif
        case (state_q)
            StIdle: begin
                if (accept) begin
`ifndef ALU_BARREL_SHIFT_EN
                    if (is_shift && (shamt != '0)) begin
                        acc_d   = in1;
                        cnt_d   = shamt;
                        left_d  = (sel == 4'd4);
                        arith_d = (sel == 4'd5) && alt;
                        state_d = StShift;
                    end else begin
                        out_d   = imm_res;
                        state_d = StDone;
                    end
`else
                    out_d   = imm_res;
                    state_d = StDone;
`endif
                end
            end
`ifndef ALU_BARREL_SHIFT_EN
            StShift: begin
                acc_d = shifted;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == SHAMT_W'(1)) begin
                    out_d   = shifted;
                    state_d = StDone;
                end
            end
`endif
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            out_q   <= '0;
`ifndef ALU_BARREL_SHIFT_EN
            acc_q   <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
`ifndef ALU_BARREL_SHIFT_EN
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            arith_q <= arith_d;
`endif
        end
    end

    assign in_ready  = rst_n && (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out       = out_q;

endmodule
